// File: rtl/endscreen_pkg.sv
// ---------------------------------------------------------------------------
// endscreen_pkg
// Shared types and constants for the end-of-game overlay sequencer.
//   state_t   : sequencer phase (IDLE waiting for an outcome, DELAY counting
//               frames before drawing, SHOW drawing the overlay)
//   outcome_t : latched game outcome, encoded as it appears on the outcome port
//   CH_*      : fixed roles of the overlay channels
// ---------------------------------------------------------------------------
package endscreen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DELAY = 2'b01,
        SHOW  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        WIN  = 2'b01,
        LOSS = 2'b10
    } outcome_t;

    // Channel roles: win banner, loss banner, then the shared blinking prompts.
    localparam int CH_WIN         = 0;
    localparam int CH_LOSS        = 1;
    localparam int CH_PROMPT_BASE = 2;

endpackage

// File: rtl/endscreen_sequencer_if.sv
// ---------------------------------------------------------------------------
// endscreen_sequencer_if
// Bundles the frame, layer and outcome signals of the end-screen sequencer.
//   start_of_frame  : one-cycle pulse per video frame
//   input_requests  : per-layer draw request            [NUM_CH-1:0]
//   input_rgb       : per-layer colour                  [NUM_CH-1:0][RGB_W-1:0]
//   is_win/is_loss  : game outcome levels
//   restart         : one-cycle pulse, clears the outcome
//   drawing_request : registered draw request to the layer mux
//   rgb             : registered colour to the layer mux
//   screen_active   : high while the overlay is showing
//   outcome         : 00 none, 01 win, 10 loss
// master = the producer of frame/layer/outcome inputs, slave = the sequencer.
// ---------------------------------------------------------------------------
interface endscreen_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int RGB_W  = 8
);

    logic                          start_of_frame;
    logic [NUM_CH-1:0]             input_requests;
    logic [NUM_CH-1:0][RGB_W-1:0]  input_rgb;
    logic                          is_win;
    logic                          is_loss;
    logic                          restart;
    logic                          drawing_request;
    logic [RGB_W-1:0]              rgb;
    logic                          screen_active;
    logic [1:0]                    outcome;

    modport master (
        output start_of_frame,
        output input_requests,
        output input_rgb,
        output is_win,
        output is_loss,
        output restart,
        input  drawing_request,
        input  rgb,
        input  screen_active,
        input  outcome
    );

    modport slave (
        input  start_of_frame,
        input  input_requests,
        input  input_rgb,
        input  is_win,
        input  is_loss,
        input  restart,
        output drawing_request,
        output rgb,
        output screen_active,
        output outcome
    );

endinterface

// File: rtl/endscreen_sequencer_layer_priority_mux.sv
// ---------------------------------------------------------------------------
// layer_priority_mux
// Combinational lowest-index-first selection among overlay layers.
//   i_requests : per-layer draw request
//   i_enable   : per-layer enable mask
//   i_rgb      : per-layer colour
//   o_hit      : at least one layer is both requesting and enabled
//   o_rgb      : colour of the lowest-index such layer, 0 when none
// ---------------------------------------------------------------------------
module layer_priority_mux #(
    parameter int NUM_CH = 4,
    parameter int RGB_W  = 8
) (
    input  logic [NUM_CH-1:0]            i_requests,
    input  logic [NUM_CH-1:0]            i_enable,
    input  logic [NUM_CH-1:0][RGB_W-1:0] i_rgb,
    output logic                         o_hit,
    output logic [RGB_W-1:0]             o_rgb
);

    logic [NUM_CH-1:0] w_active;

    assign w_active = i_requests & i_enable;

    // Walk from the highest index down so the lowest active index is the last to write.
    always_comb begin
        o_hit = |w_active;
        o_rgb = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            o_rgb = w_active[i] ? i_rgb[i] : o_rgb;
        end
    end

endmodule

// File: rtl/endscreen_sequencer.sv
// ---------------------------------------------------------------------------
// endscreen_sequencer
// End-of-game overlay stage in the VGA path. Latches win/loss, waits
// DELAY_FRAMES frames, then draws the outcome banner and the blinking shared
// prompt layers through one registered drawing_request/rgb pair.
//   clk  : pixel clock
//   rst  : asynchronous reset, active-high
//   bus  : endscreen_sequencer_if.slave (frame pulse, layer requests/colours,
//          outcome inputs, restart; drawing_request, rgb, screen_active,
//          outcome outputs)
// Parameters:
//   NUM_CH       overlay channels (>= 3): ch0 win, ch1 loss, ch2.. prompts
//   RGB_W        colour width
//   DELAY_FRAMES frames from outcome latch to drawing; 0 draws immediately
//   BLINK_FRAMES frames per blink half-period of the prompt layers (>= 1)
//   CNT_W        frame counter width, holds max(DELAY_FRAMES, BLINK_FRAMES)
// ---------------------------------------------------------------------------
module endscreen_sequencer
    import endscreen_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int RGB_W        = 8,
    parameter int DELAY_FRAMES = 30,
    parameter int BLINK_FRAMES = 16,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    endscreen_sequencer_if.slave  bus
);

    // Terminal counter values; DELAY_LAST is unused when DELAY_FRAMES is 0.
    localparam logic [CNT_W-1:0] DELAY_LAST =
        (DELAY_FRAMES == 0) ? '0 : CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    outcome_t           r_outcome;
    outcome_t           w_outcome_nxt;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   w_frame_cnt_nxt;
    logic [CNT_W-1:0]   r_blink_cnt;
    logic [CNT_W-1:0]   w_blink_cnt_nxt;
    logic               r_blink_on;
    logic               w_blink_on_nxt;

    logic [NUM_CH-1:0]  w_enable;
    logic               w_hit;
    logic [RGB_W-1:0]   w_hit_rgb;
    logic               w_show_now;

    logic               r_drawing_request;
    logic [RGB_W-1:0]   r_rgb;
    logic               r_screen_active;

    // Sequencer state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_outcome   <= NONE;
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_outcome   <= w_outcome_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_on  <= w_blink_on_nxt;
        end
    end

    // Next-state logic: restart wins over every other event in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_outcome_nxt   = r_outcome;
        w_frame_cnt_nxt = r_frame_cnt;
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_on_nxt  = r_blink_on;

        if (bus.restart) begin
            w_state_nxt     = IDLE;
            w_outcome_nxt   = NONE;
            w_frame_cnt_nxt = '0;
            w_blink_cnt_nxt = '0;
            w_blink_on_nxt  = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // Outcome is only sampled here, which makes it sticky afterwards.
                    if (bus.is_win || bus.is_loss) begin
                        w_outcome_nxt   = bus.is_win ? WIN : LOSS;
                        w_frame_cnt_nxt = '0;
                        w_blink_cnt_nxt = '0;
                        w_blink_on_nxt  = 1'b1;
                        w_state_nxt     = (DELAY_FRAMES == 0) ? SHOW : DELAY;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                DELAY: begin
                    if (bus.start_of_frame) begin
                        if (r_frame_cnt == DELAY_LAST) begin
                            w_state_nxt     = SHOW;
                            w_frame_cnt_nxt = '0;
                            w_blink_cnt_nxt = '0;
                            w_blink_on_nxt  = 1'b1;
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt;
                    end
                end
                SHOW: begin
                    if (bus.start_of_frame) begin
                        if (r_blink_cnt == BLINK_LAST) begin
                            w_blink_cnt_nxt = '0;
                            w_blink_on_nxt  = ~r_blink_on;
                        end else begin
                            w_blink_cnt_nxt = r_blink_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_blink_cnt_nxt = r_blink_cnt;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    w_state_nxt     = IDLE;
                    w_outcome_nxt   = NONE;
                    w_frame_cnt_nxt = '0;
                    w_blink_cnt_nxt = '0;
                    w_blink_on_nxt  = 1'b1;
                end
            endcase
        end
    end

    // Layer enable mask: banners follow the outcome, prompt layers follow the blink phase.
    always_comb begin
        w_enable          = '0;
        w_enable[CH_WIN]  = (r_outcome == WIN);
        w_enable[CH_LOSS] = (r_outcome == LOSS);
        for (int i = CH_PROMPT_BASE; i < NUM_CH; i++) begin
            w_enable[i] = r_blink_on;
        end
    end

    layer_priority_mux #(
        .NUM_CH (NUM_CH),
        .RGB_W  (RGB_W)
    ) u_layer_priority_mux (
        .i_requests (bus.input_requests),
        .i_enable   (w_enable),
        .i_rgb      (bus.input_rgb),
        .o_hit      (w_hit),
        .o_rgb      (w_hit_rgb)
    );

    // A restart blanks the overlay on the same edge that sends the sequencer to IDLE.
    assign w_show_now = (r_state == SHOW) && !bus.restart;

    // Registered overlay outputs, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drawing_request <= 1'b0;
            r_rgb             <= '0;
            r_screen_active   <= 1'b0;
        end else begin
            r_drawing_request <= w_show_now && w_hit;
            r_rgb             <= (w_show_now && w_hit) ? w_hit_rgb : '0;
            r_screen_active   <= w_show_now;
        end
    end

    assign bus.drawing_request = r_drawing_request;
    assign bus.rgb             = r_rgb;
    assign bus.screen_active   = r_screen_active;
    assign bus.outcome         = r_outcome;

endmodule

// File: tb/tb_endscreen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_endscreen_sequencer
// Two sequencers share one stimulus stream: u_dut_d3 (DELAY_FRAMES=3) and
// u_dut_d0 (DELAY_FRAMES=0), both with NUM_CH=4, BLINK_FRAMES=2.
// A frame-counting reference model checks every output of both instances on
// every clock; directed sequences and a vector table add hand-derived checks.
// ---------------------------------------------------------------------------
module tb_endscreen_sequencer;

    localparam int NUM_CH = 4;
    localparam int RGB_W  = 8;
    localparam int BLINK  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sof = 1'b0;
    logic [3:0]        req = 4'd0;
    logic [3:0][7:0]   rgb_in = 32'd0;
    logic              is_win = 1'b0;
    logic              is_loss = 1'b0;
    logic              restart = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    endscreen_sequencer_if #(.NUM_CH(NUM_CH), .RGB_W(RGB_W)) bus_d3 ();
    endscreen_sequencer_if #(.NUM_CH(NUM_CH), .RGB_W(RGB_W)) bus_d0 ();

    assign bus_d3.start_of_frame = sof;
    assign bus_d3.input_requests = req;
    assign bus_d3.input_rgb      = rgb_in;
    assign bus_d3.is_win         = is_win;
    assign bus_d3.is_loss        = is_loss;
    assign bus_d3.restart        = restart;
    assign bus_d0.start_of_frame = sof;
    assign bus_d0.input_requests = req;
    assign bus_d0.input_rgb      = rgb_in;
    assign bus_d0.is_win         = is_win;
    assign bus_d0.is_loss        = is_loss;
    assign bus_d0.restart        = restart;

    endscreen_sequencer #(
        .NUM_CH(NUM_CH), .RGB_W(RGB_W), .DELAY_FRAMES(3), .BLINK_FRAMES(BLINK), .CNT_W(8)
    ) u_dut_d3 (
        .clk (clk),
        .rst (rst),
        .bus (bus_d3)
    );

    endscreen_sequencer #(
        .NUM_CH(NUM_CH), .RGB_W(RGB_W), .DELAY_FRAMES(0), .BLINK_FRAMES(BLINK), .CNT_W(8)
    ) u_dut_d0 (
        .clk (clk),
        .rst (rst),
        .bus (bus_d0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- reference model ----------------
    // The overlay is visible once at least `dly` frame pulses have been seen
    // since the outcome was latched; the blink phase is the number of frames
    // spent showing, divided into halves of BLINK frames.
    function automatic logic model_showing(input logic latched, input int sofs,
                                           input int dly, input logic rs);
        return latched && (sofs >= dly) && !rs;
    endfunction

    function automatic logic [8:0] model_pixel(input logic latched, input logic [1:0] oc,
                                               input int sofs, input int dly, input logic rs,
                                               input logic [3:0] rq, input logic [31:0] col);
        logic [8:0] res;
        logic       blink;
        logic       en;
        res   = 9'd0;
        blink = (((sofs - dly) / BLINK) % 2) == 0;
        if (model_showing(latched, sofs, dly, rs)) begin
            for (int i = 3; i >= 0; i--) begin
                if (i == 0)      en = (oc == 2'b01);
                else if (i == 1) en = (oc == 2'b10);
                else             en = blink;
                if (rq[i] && en) res = {1'b1, col[i*8 +: 8]};
            end
        end
        return res;
    endfunction

    logic       m_latched [2];
    logic [1:0] m_oc      [2];
    int         m_sofs    [2];
    logic [8:0] e_pix     [2];
    logic       e_sa      [2];
    logic [1:0] e_oc      [2];
    logic       a_dr      [2];
    logic [7:0] a_rgb     [2];
    logic       a_sa      [2];
    logic [1:0] a_oc      [2];

    assign a_dr[0]  = bus_d3.drawing_request;
    assign a_rgb[0] = bus_d3.rgb;
    assign a_sa[0]  = bus_d3.screen_active;
    assign a_oc[0]  = bus_d3.outcome;
    assign a_dr[1]  = bus_d0.drawing_request;
    assign a_rgb[1] = bus_d0.rgb;
    assign a_sa[1]  = bus_d0.screen_active;
    assign a_oc[1]  = bus_d0.outcome;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_latched[d] = 1'b0;
                m_oc[d]      = 2'b00;
                m_sofs[d]    = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                e_pix[d] = model_pixel(m_latched[d], m_oc[d], m_sofs[d], (d == 0) ? 3 : 0,
                                       restart, req, rgb_in);
                e_sa[d]  = model_showing(m_latched[d], m_sofs[d], (d == 0) ? 3 : 0, restart);
                if (restart) begin
                    m_latched[d] = 1'b0;
                    m_oc[d]      = 2'b00;
                    m_sofs[d]    = 0;
                end else if (!m_latched[d]) begin
                    if (is_win || is_loss) begin
                        m_latched[d] = 1'b1;
                        m_oc[d]      = is_win ? 2'b01 : 2'b10;
                        m_sofs[d]    = 0;
                    end
                end else if (sof) begin
                    m_sofs[d] = m_sofs[d] + 1;
                end
                e_oc[d] = m_oc[d];
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                chk((d == 0) ? "model_dr_d3"  : "model_dr_d0",  {31'd0, a_dr[d]}, {31'd0, e_pix[d][8]});
                chk((d == 0) ? "model_rgb_d3" : "model_rgb_d0", {24'd0, a_rgb[d]}, {24'd0, e_pix[d][7:0]});
                chk((d == 0) ? "model_sa_d3"  : "model_sa_d0",  {31'd0, a_sa[d]}, {31'd0, e_sa[d]});
                chk((d == 0) ? "model_oc_d3"  : "model_oc_d0",  {30'd0, a_oc[d]}, {30'd0, e_oc[d]});
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0] req;
        logic       exp_dr;
        logic [7:0] exp_rgb;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] blink_exp [5];

    initial begin
        // Colours: ch3=33 ch2=FF ch1=1C ch0=E0. Table applies in SHOW with loss, blink on.
        vecs[0] = '{4'b0001, 1'b0, 8'h00};
        vecs[1] = '{4'b0010, 1'b1, 8'h1C};
        vecs[2] = '{4'b0110, 1'b1, 8'h1C};
        vecs[3] = '{4'b0100, 1'b1, 8'hFF};
        vecs[4] = '{4'b1000, 1'b1, 8'h33};
        vecs[5] = '{4'b1100, 1'b1, 8'hFF};
        vecs[6] = '{4'b0000, 1'b0, 8'h00};
        vecs[7] = '{4'b0101, 1'b1, 8'hFF};
        blink_exp[0] = 8'hFF;
        blink_exp[1] = 8'h00;
        blink_exp[2] = 8'h00;
        blink_exp[3] = 8'hFF;
        blink_exp[4] = 8'hFF;

        #1 rst = 1'b1;
        #20 rst = 1'b0;
        chk("reset_dr",  {31'd0, bus_d3.drawing_request}, 32'd0);
        chk("reset_rgb", {24'd0, bus_d3.rgb}, 32'd0);
        chk("reset_sa",  {31'd0, bus_d3.screen_active}, 32'd0);
        chk("reset_oc",  {30'd0, bus_d3.outcome}, 32'd0);
        chk("reset_sa_d0", {31'd0, bus_d0.screen_active}, 32'd0);
        tick();

        // 1: win, ch0 request, frame pulse every 10 cycles.
        rgb_in = {8'h33, 8'hFF, 8'h1C, 8'hE0};
        req    = 4'b0001;
        is_win = 1'b1;
        tick();
        is_win = 1'b0;
        for (int f = 0; f < 3; f++) begin
            repeat (9) begin
                tick();
                chk("delay_quiet_dr", {31'd0, bus_d3.drawing_request}, 32'd0);
            end
            sof = 1'b1;
            tick();
            sof = 1'b0;
            chk("sof_edge_dr", {31'd0, bus_d3.drawing_request}, 32'd0);
            chk("sof_edge_sa", {31'd0, bus_d3.screen_active}, 32'd0);
        end
        tick();
        chk("win_dr",  {31'd0, bus_d3.drawing_request}, 32'd1);
        chk("win_rgb", {24'd0, bus_d3.rgb}, 32'hE0);
        chk("win_sa",  {31'd0, bus_d3.screen_active}, 32'd1);
        chk("win_oc",  {30'd0, bus_d3.outcome}, 32'd1);

        // 2: simultaneous win/loss latches win; later loss is ignored.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        is_win  = 1'b1;
        is_loss = 1'b1;
        tick();
        is_win  = 1'b0;
        is_loss = 1'b0;
        chk("both_oc", {30'd0, bus_d3.outcome}, 32'd1);
        repeat (2) tick();
        is_loss = 1'b1;
        tick();
        is_loss = 1'b0;
        tick();
        chk("sticky_oc", {30'd0, bus_d3.outcome}, 32'd1);

        // 4: restart and loss together; loss re-latches one cycle later.
        restart = 1'b1;
        is_loss = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_oc", {30'd0, bus_d3.outcome}, 32'd0);
        tick();
        is_loss = 1'b0;
        chk("relatch_oc", {30'd0, bus_d3.outcome}, 32'd2);

        // 3: reach SHOW with loss, then the priority table and the blink pattern.
        req = 4'b0000;
        repeat (3) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            tick();
        end
        chk("loss_sa", {31'd0, bus_d3.screen_active}, 32'd1);
        for (int v = 0; v < 8; v++) begin
            req = vecs[v].req;
            tick();
            chk("table_dr",  {31'd0, bus_d3.drawing_request}, {31'd0, vecs[v].exp_dr});
            chk("table_rgb", {24'd0, bus_d3.rgb}, {24'd0, vecs[v].exp_rgb});
        end
        req = 4'b0100;
        tick();
        chk("blink_first", {24'd0, bus_d3.rgb}, 32'hFF);
        for (int k = 0; k < 5; k++) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            tick();
            chk("blink_rgb", {24'd0, bus_d3.rgb}, {24'd0, blink_exp[k]});
            chk("blink_dr",  {31'd0, bus_d3.drawing_request}, {31'd0, (blink_exp[k] != 8'h00)});
        end

        // 5: asynchronous reset in the middle of SHOW.
        req = 4'b0010;
        tick();
        chk("pre_rst_dr", {31'd0, bus_d3.drawing_request}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_dr",  {31'd0, bus_d3.drawing_request}, 32'd0);
        chk("async_rgb", {24'd0, bus_d3.rgb}, 32'd0);
        chk("async_sa",  {31'd0, bus_d3.screen_active}, 32'd0);
        chk("async_sa_d0", {31'd0, bus_d0.screen_active}, 32'd0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_oc", {30'd0, bus_d3.outcome}, 32'd0);
        chk("post_rst_dr", {31'd0, bus_d3.drawing_request}, 32'd0);
        chk("post_rst_sa", {31'd0, bus_d3.screen_active}, 32'd0);

        // 6: zero-delay build shows two cycles after the loss, no frame pulse needed.
        is_loss = 1'b1;
        tick();
        is_loss = 1'b0;
        chk("d0_sa_early", {31'd0, bus_d0.screen_active}, 32'd0);
        tick();
        chk("d0_sa", {31'd0, bus_d0.screen_active}, 32'd1);
        chk("d0_oc", {30'd0, bus_d0.outcome}, 32'd2);

        // Random traffic, checked by the reference model every cycle.
        for (int c = 0; c < 2000; c++) begin
            sof     = ($urandom_range(3) == 0);
            req     = 4'($urandom);
            rgb_in  = $urandom;
            is_win  = ($urandom_range(15) == 0);
            is_loss = ($urandom_range(15) == 0);
            restart = ($urandom_range(79) == 0);
            tick();
        end
        sof     = 1'b0;
        req     = 4'd0;
        is_win  = 1'b0;
        is_loss = 1'b0;
        restart = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
